flop_pipe: RTL
==============

Name: flop_pipe

Overview:
- Parametrised successor to the plain D-register: a DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits.
- Uses valid/ready handshaking with bubble collapsing, plus a synchronous flush and an occupancy count.
- Sits between datapath blocks that need registered timing cuts and must tolerate downstream stalls without losing or duplicating data.

Parameters:
- WIDTH, 4, data bits per stage.
- DEPTH, 2, number of register stages; must be >= 1 (elaboration-time $error otherwise).
- RESET_VAL, '0, data register value after reset (used only with FLOP_PIPE_DATA_RST_EN).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream has data.
- in_ready  output  1  pipeline accepts data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds data.
- out_ready  input  1  downstream accepts data.
- out_data  output  WIDTH  last stage data.
- count  output  $clog2(DEPTH+1)  number of stages currently valid.

Behaviour:
- Interface: one clock (clk); asynchronous, active-low reset (reset_n).
- Reset (reset_n low, asynchronous): all stage valids = 0.
  - Resulting outputs: out_valid = 0, count = 0, in_ready = 1 (once flush is low).
  - Data registers as per the Optional Feature section.
  - Reset asserted mid-transfer discards all contents; nothing is replayed.
- Stage i holds v[i], d[i]; stage 0 is the input side, stage DEPTH-1 the output side.
- Ready chain (combinational): rdy[DEPTH] = out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !flush.
- Per stage, per clock:
  - If rdy[i]: v[i] <= v[i-1] (stage 0 takes in_valid & in_ready) and d[i] <= d[i-1] (stage 0 takes in_data), loading data only when the incoming valid is 1.
  - If !rdy[i]: the stage holds.
- Bubble collapsing: an empty stage always accepts, so a stalled pipeline fills completely before in_ready drops.
- Output transfer when out_valid & out_ready; input transfer when in_valid & in_ready.
- Latency: DEPTH cycles from input transfer to out_valid with no stall. Throughput: 1 item/cycle sustained.
- out_data is stable while out_valid & !out_ready (no change under stall).
- Full: all v = 1 and out_ready = 0 -> in_ready = 0.
  - With all stages full and out_ready = 1, in_ready = 1 (simultaneous in/out in one cycle).
- count: registered popcount of v.
  - Updates +1 on input-only transfer, -1 on output-only transfer, unchanged when both or neither occur.
  - Saturation is impossible by construction.
- flush = 1: next cycle all v = 0 and count = 0.
  - in_ready is forced 0 during flush, so no input is accepted.
  - An output transfer in the flush cycle still counts as delivered to downstream.
  - Flush during reset has no effect.

Optional Feature:
- Macro FLOP_PIPE_DATA_RST_EN.
- Defined: every d[i] resets asynchronously to RESET_VAL, so out_data = RESET_VAL after reset.
- Undefined: data registers have no reset (smaller, better-packing flops); out_data is undefined until the first valid item reaches the output. Only valids and count reset.
- Handshake behaviour is identical in both builds.

Decomposition:
- Package flop_pkg: default width/depth localparams (FLOP_DEF_WIDTH = 4, FLOP_DEF_DEPTH = 2) and a count-width function cnt_w(depth) = $clog2(depth+1).
- Sub-module flop_stage: one valid+data stage with inputs clk, reset_n, flush, up_valid, up_data, dn_ready; outputs valid, data, rdy.
- flop_pipe instantiates DEPTH copies of flop_stage in a generate loop and adds the count register.

Test Plan:
- Reset: hold reset_n low 3 cycles while in_valid = 1 -> out_valid = 0, count = 0, in_ready = 1. With macro, out_data = RESET_VAL.
- Streaming: DEPTH = 3, WIDTH = 8, out_ready = 1, push 0x01..0x0A on consecutive cycles -> 0x01 appears 3 cycles after its input transfer, then one item/cycle in order, no gaps; count steady at 3.
- Stall and fill: out_ready = 0, push 0xA1, 0xA2, 0xA3 -> in_ready drops after the third accept, count = 3, out_data holds 0xA1. Then raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order, no duplicates.
- Full with simultaneous in/out: pipeline full, out_ready = 1 and in_valid = 1 with 0x55 -> in_ready = 1 in the same cycle; count stays 3; 0x55 emerges 3 items later.
- Flush: count = 2, pulse flush 1 cycle with in_valid = 1 -> in_ready = 0 that cycle; next cycle count = 0, out_valid = 0; the flushed data never appears.
- Async reset mid-stream: assert reset_n low between clock edges with count = 2 -> out_valid = 0 immediately (before the next edge). After release, the first new input appears after DEPTH cycles.

Source files
------------

// File: rtl/flop_pkg.sv
// flop_pkg: shared defaults and helpers for the flop_pipe register pipeline.
package flop_pkg;

  localparam int FLOP_DEF_WIDTH = 4;
  localparam int FLOP_DEF_DEPTH = 2;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_if.sv
// flop_pipe_if: upstream/downstream handshake bundle for flop_pipe.
// master = the environment around the pipe, slave = the pipe itself.
interface flop_pipe_if
  import flop_pkg::*;
#(
  parameter int WIDTH = FLOP_DEF_WIDTH,
  parameter int DEPTH = FLOP_DEF_DEPTH
);
  localparam int CW = cnt_w(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/flop_stage.sv
// flop_stage: one valid+data register slot of flop_pipe.
// Data reset only exists when FLOP_PIPE_DATA_RST_EN is defined.
module flop_stage
  import flop_pkg::*;
#(
  parameter int               WIDTH     = FLOP_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  // An empty slot always accepts; a full one only if its contents move on.
  assign rdy = !valid | dn_ready;

  // Valid bit: cleared by reset or flush, otherwise follows upstream when moving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (rdy)   valid <= up_valid;
  end

`ifdef FLOP_PIPE_DATA_RST_EN
  // Data register with reset value; loads only real items.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               data <= RESET_VAL;
    else if (rdy && up_valid)   data <= up_data;
  end
`else
  // Reset-free data register; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (rdy && up_valid) data <= up_data;
  end

  logic unused_rst_val;
  assign unused_rst_val = ^RESET_VAL;
`endif

endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage, WIDTH-bit valid/ready register pipeline with
// bubble collapsing, synchronous flush and registered occupancy count.
// Optional: FLOP_PIPE_DATA_RST_EN gives the data registers a reset to RESET_VAL.
module flop_pipe
  import flop_pkg::*;
#(
  parameter int               WIDTH     = FLOP_DEF_WIDTH,
  parameter int               DEPTH     = FLOP_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  flop_pipe_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("flop_pipe: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
  logic                        head_rdy;
  logic                        in_xfer;
  logic                        out_xfer;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_nxt;

  assign bus.in_ready  = head_rdy & !bus.flush;
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld_pipe[DEPTH-1];
  assign bus.out_data  = dat_pipe[DEPTH-1];
  assign out_xfer      = bus.out_valid & bus.out_ready;
  assign bus.count     = cnt_q;

  // Stage chain. The downstream-ready of stage i is the unrolled ready chain:
  // stage i+1 can take data unless every stage from i+1 to the output is
  // full and the output is stalled. Computing it from valids keeps the
  // chain free of self-referencing combinational vectors.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_r;
    logic             st_rdy;

    if (i == 0) begin : g_head
      assign up_v     = in_xfer;
      assign up_d     = bus.in_data;
      assign head_rdy = st_rdy;
    end else begin : g_body
      logic unused_rdy;
      assign up_v       = vld_pipe[i-1];
      assign up_d       = dat_pipe[i-1];
      assign unused_rdy = st_rdy;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_r = bus.out_ready;
    end else begin : g_mid
      assign dn_r = bus.out_ready | ~(&vld_pipe[DEPTH-1:i+1]);
    end

    flop_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (bus.flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (dn_r),
      .valid    (vld_pipe[i]),
      .data     (dat_pipe[i]),
      .rdy      (st_rdy)
    );
  end

  // Occupancy next-state: +1 on input-only, -1 on output-only, 0 on flush.
  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.flush) begin
      cnt_nxt = '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   cnt_nxt = cnt_q + CW'(1);
        2'b01:   cnt_nxt = cnt_q - CW'(1);
        default: cnt_nxt = cnt_q;
      endcase
    end
  end

  // Occupancy register; tracks the popcount of the stage valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_nxt;
  end

endmodule
